// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
//   Commit-trace capture stage. Every cycle it snoops the regfile write port
//   and the dmem write port and logs each architectural write as a 57-bit
//   entry {kind, pc, dest, value} in a small register-array FIFO. Entries
//   drain through a first-word-fall-through valid/ready stream. Entries that
//   find no free slot are dropped and counted.
//
// Ports
//   clock, reset          processor clock, async active-high reset
//   trace_enable          capture enable (disabled events are not drops)
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg   regfile write snoop
//   wren/address_dmem/data                         dmem write snoop
//   address_imem          PC tag attached to every entry this cycle
//   trace_valid/trace_ready/trace_data             output stream (FWFT)
//   trace_count           current occupancy, 0..DEPTH
//   overflow, drop_count  sticky drop flag and saturating drop counter
//   clear_overflow        synchronous clear of overflow and drop_count

module wb_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter bit LOG_R0 = 1'b0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       trace_enable,
    input  logic                       ctrl_writeEnable,
    input  logic [4:0]                 ctrl_writeReg,
    input  logic [31:0]                data_writeReg,
    input  logic                       wren,
    input  logic [11:0]                address_dmem,
    input  logic [31:0]                data,
    input  logic [11:0]                address_imem,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [56:0]                trace_data,
    output logic [$clog2(DEPTH):0]     trace_count,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    input  logic                       clear_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [56:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW:0]   wr_next, rd_next, count_next;
    logic [AW-1:0] wr_idx0, wr_idx1;
    logic [AW+1:0] free_slots;
    logic [1:0]    n_ev, n_push, n_drop;
    logic          reg_ev, mem_ev, pop;
    logic [56:0]   reg_entry, mem_entry, first_entry, head_next;
    logic [16:0]   drop_sum;

    // Occupancy comes straight from the pointers; the extra MSB keeps a full
    // FIFO (difference DEPTH) distinct from an empty one (difference 0).
    assign trace_count = wr_ptr - rd_ptr;
    assign trace_valid = (trace_count != '0);

    // Event decode, space allocation and next-head selection.
    // The RegEv always takes the first free slot, so when only one slot is
    // available it is the MemEv that is lost.
    always_comb begin
        reg_ev      = trace_enable && ctrl_writeEnable &&
                      ((ctrl_writeReg != 5'd0) || LOG_R0);
        mem_ev      = trace_enable && wren;
        pop         = trace_valid && trace_ready;
        reg_entry   = {1'b0, address_imem, 7'b0, ctrl_writeReg, data_writeReg};
        mem_entry   = {1'b1, address_imem, address_dmem, data};
        first_entry = reg_ev ? reg_entry : mem_entry;

        // A pop at this edge frees its slot for the pushes at the same edge.
        free_slots  = (AW+2)'(DEPTH) - {1'b0, trace_count} + {{(AW+1){1'b0}}, pop};
        n_ev        = {1'b0, reg_ev} + {1'b0, mem_ev};
        if (free_slots >= (AW+2)'(n_ev))
            n_push = n_ev;
        else
            n_push = free_slots[1:0];
        n_drop      = n_ev - n_push;

        wr_idx0     = wr_ptr[AW-1:0];
        wr_idx1     = wr_ptr[AW-1:0] + AW'(1);
        wr_next     = wr_ptr + (AW+1)'(n_push);
        rd_next     = rd_ptr + (AW+1)'(pop);
        count_next  = wr_next - rd_next;

        // If the new head sits exactly where the first push lands, the entry
        // is not in the array yet, so forward it from the write side.
        if (rd_next == wr_ptr)
            head_next = first_entry;
        else
            head_next = mem[rd_next[AW-1:0]];

        // Clear and same-cycle drops: the clear zeroes the base, drops add on.
        drop_sum = {1'b0, (clear_overflow ? 16'h0000 : drop_count)} + {15'b0, n_drop};
    end

    // Pointers, registered head output and drop bookkeeping. trace_data only
    // moves when there will be a head next cycle, so it holds its last value
    // while the FIFO is empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            trace_data <= '0;
            overflow   <= 1'b0;
            drop_count <= 16'h0000;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            if (count_next != '0)
                trace_data <= head_next;
            if (n_drop != 2'd0) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end else if (clear_overflow) begin
                overflow   <= 1'b0;
                drop_count <= 16'h0000;
            end
        end
    end

    // Entry storage. Up to two writes per edge into consecutive slots.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (n_push != 2'd0)
                mem[wr_idx0] <= first_entry;
            if (n_push == 2'd2)
                mem[wr_idx1] <= mem_entry;
        end
    end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Commit-trace capture stage downstream of the processor skeleton.
- Snoops the regfile write port and dmem write port each cycle and logs every architectural write as an entry in an on-chip FIFO, tagged with the current imem address.
- Entries drain through a valid/ready stream to the bench checker or a debug UART.
- Decouples bursty writeback from a slower consumer and flags lost entries.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 4.
- LOG_R0, 0, 1 = log writes to register $r0; 0 = discard them.

Ports:
- clock  in  1  processor clock; all sampling on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- trace_enable  in  1  capture enable; 0 = ignore all events (not counted as drops).
- ctrl_writeEnable  in  1  regfile write strobe.
- ctrl_writeReg  in  5  regfile destination.
- data_writeReg  in  32  regfile write data.
- wren  in  1  dmem write strobe.
- address_dmem  in  12  dmem address.
- data  in  32  dmem write data.
- address_imem  in  12  PC tag for this cycle.
- trace_valid  out  1  head entry available.
- trace_ready  in  1  consumer accepts head.
- trace_data  out  57  {kind[56], pc[55:44], dest[43:32], value[31:0]}.
- trace_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one entry dropped.
- drop_count  out  16  dropped entries, saturates at 16'hFFFF.
- clear_overflow  in  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset (async): FIFO empty, trace_valid=0, trace_data=0, trace_count=0, overflow=0, drop_count=0. Reset mid-drain discards all entries.
- Event sampling on each rising edge when trace_enable=1:
  - RegEv: ctrl_writeEnable=1 and (ctrl_writeReg!=0 or LOG_R0=1). Entry kind=0, pc=address_imem, dest={7'b0,ctrl_writeReg}, value=data_writeReg.
  - MemEv: wren=1. Entry kind=1, pc=address_imem, dest=address_dmem, value=data.
- Up to two pushes per cycle. When both occur, RegEv goes in first and MemEv second (FIFO order).
- Pop: when trace_valid && trace_ready at the edge, the head is removed.
- Free slots this cycle = DEPTH - trace_count + (pop ? 1 : 0). A pop frees its slot for same-edge pushes.
- Space allocation:
  - 2 events and free>=2: push both.
  - 2 events and free==1: push RegEv only; MemEv dropped.
  - free==0: all events dropped.
- Each dropped entry sets overflow=1 and increments drop_count by 1 (by 2 if both dropped), saturating.
- clear_overflow=1 zeroes overflow and drop_count at the edge. Drops in the same cycle win: the result is overflow=1 and drop_count = drops this cycle.
- Output is first-word fall-through:
  - An entry pushed into an empty FIFO at edge N gives trace_valid=1 with its data in the cycle after edge N (1-cycle latency).
  - trace_data holds the head stable while trace_valid=1 and trace_ready=0.
  - trace_data is don't-care-but-stable (last value) when trace_valid=0.
- trace_count updates at the edge: count + pushes - pop, range 0..DEPTH.
- trace_valid = (trace_count != 0).
- Read and write pointers wrap modulo DEPTH. An extra MSB distinguishes full from empty.
- Storage is a register array (no memory IP).

Test Plan:
- Reset: hold reset mid-cycle with 3 entries queued -> immediately trace_valid=0, trace_count=0, overflow=0, drop_count=0.
- Single regwrite: $r5 <- 32'h0000_0007 at address_imem=12'h004, ready=1 -> next cycle trace_valid=1, trace_data={1'b0,12'h004,12'h005,32'h7}; popped the following edge, count returns to 0.
- $r0 filter: write $r0 with LOG_R0=0 -> no entry, drop_count stays 0. Same stimulus with LOG_R0=1 -> one entry with dest=0.
- Dual event: same cycle $r3 <- 32'hAA and dmem[12'h010] <- 32'hBB, pc=12'h020 -> count=2. Reg entry is read first, then {1'b1,12'h020,12'h010,32'hBB}.
- Overflow: ready=0, 18 single regwrites with DEPTH=16 -> count=16, overflow=1, drop_count=2.
  - At full with 2 events and ready=1 -> one pushed, MemEv dropped, drop_count=3.
  - clear_overflow -> overflow=0, drop_count=0.
- Wrap and throughput: ready=1 continuously, 40 consecutive regwrites -> all 40 emerged in order, count never exceeds 1, no drops. Pointers wrap twice.
